// File: rtl/inst_fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : inst_fetch_pkg
// Description : Shared CPU constants: reset PC, NOP encoding, fetch FSM
//               state encoding, base opcodes and write-back select codes,
//               plus a small PC arithmetic helper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam logic [31:0] c_reset_pc  = 32'h0000_3000;
    localparam logic [31:0] c_nop_inst  = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    // Base opcodes (inst[6:0])
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;

    // Write-back source select
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_pc_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pc_reg
// Description : 32-bit program-counter register with load enable.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               i_load       - load i_next_pc on the next rising edge
//               i_next_pc    - next PC value
//               o_pc         - current PC value
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_next_pc,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_next_pc;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : inst_fetch
// Description : Instruction fetch unit. Issues single-outstanding reads to
//               instruction memory, holds the fetched word for the decoder,
//               honours downstream stall and flushes on redirect.
// Ports       : clk, rst                 - clock, asynchronous active-high reset
//               stall                    - decoder cannot accept inst this cycle
//               redirect, redirect_pc    - taken control transfer, new target
//               imem_req/addr/gnt        - request handshake
//               imem_rvalid/rdata        - read response
//               inst, pc_cur, pc_add4    - instruction, its address, link value
//               inst_valid               - inst/pc_cur hold a live instruction
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter logic [31:0] NOP_INST = c_nop_inst
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc_cur,
    output logic [31:0] pc_add4,
    output logic        inst_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         r_drop;
    logic         w_drop_next;
    logic [31:0]  r_inst;
    logic [31:0]  r_pc_cur;
    logic         r_inst_valid;
    logic [31:0]  w_fetch_pc;
    logic [31:0]  w_fetch_pc_next;
    logic         w_fetch_pc_load;
    logic         w_out_free;
    logic         w_req;
    logic         w_accept;

    // Output slot is free if empty or being consumed this cycle; only then
    // may a new read be issued, so a response never finds the slot occupied.
    assign w_out_free = !r_inst_valid || !stall;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_fetch_pc_load),
        .i_next_pc (w_fetch_pc_next),
        .o_pc      (w_fetch_pc)
    );

    assign w_fetch_pc_load = redirect || w_accept;
    assign w_fetch_pc_next = redirect ? (redirect_pc & c_word_mask) : pc_inc4(w_fetch_pc);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
        end
    end

    // FSM next state and request generation
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        w_req        = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
            end
            ST_REQ: begin
                w_req = w_out_free;
                if (w_req && imem_gnt) begin
                    w_state_next = ST_WAIT;
                    // Redirect on the grant cycle: the read now in flight
                    // belongs to the old path and must be discarded.
                    w_drop_next  = redirect;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = ST_REQ;
                    w_drop_next  = 1'b0;
                    w_accept     = !r_drop && !redirect;
                end else if (redirect) begin
                    // Stay in WAIT until the stale read returns so that only
                    // one request is ever outstanding.
                    w_drop_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output instruction slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst       <= NOP_INST;
            r_pc_cur     <= RESET_PC;
            r_inst_valid <= 1'b0;
        end else if (redirect) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
        end else if (w_accept) begin
            r_inst       <= imem_rdata;
            r_pc_cur     <= w_fetch_pc;
            r_inst_valid <= 1'b1;
        end else if (!stall) begin
            r_inst_valid <= 1'b0;
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = w_fetch_pc & c_word_mask;
    assign inst       = r_inst_valid ? r_inst : NOP_INST;
    assign pc_cur     = r_pc_cur;
    assign pc_add4    = pc_inc4(r_pc_cur);
    assign inst_valid = r_inst_valid;

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, address of first fetched instruction after reset.
REQ-002 Parameter NOP_INST, 32'h0000_0013, value driven on inst while no valid instruction is held.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall  in  1  downstream cannot accept inst this cycle (hazard or data-memory wait).
REQ-006 redirect  in  1  taken jal, jalr or branch resolved downstream; flush and refetch.
REQ-007 redirect_pc  in  32  redirect target.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  32  word-aligned request address.
REQ-010 imem_gnt  in  1  request accepted this cycle.
REQ-011 imem_rvalid  in  1  read data valid; 1 or more cycles after grant.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 inst  out  32  instruction presented to the control decoder.
REQ-014 pc_cur  out  32  address of inst.
REQ-015 pc_add4  out  32  pc_cur + 4, link value for jal/jalr write-back.
REQ-016 inst_valid  out  1  inst/pc_cur hold a live instruction.

Function
REQ-017 FSM states IDLE, REQ, WAIT; IDLE -> REQ unconditionally on first clock after reset release.
REQ-018 REQ: imem_req=1 and imem_addr=fetch_pc only when output is free (inst_valid=0, or inst_valid=1 and stall=0); otherwise imem_req=0.
REQ-019 REQ -> WAIT on imem_req&&imem_gnt; at most one request outstanding at any time.
REQ-020 WAIT, imem_rvalid=1, no drop pending: inst<=imem_rdata, pc_cur<=fetch_pc, inst_valid<=1, fetch_pc<=fetch_pc+4, state -> REQ.
REQ-021 Output consumed when inst_valid&&!stall; inst_valid clears that cycle unless refilled; inst/pc_cur hold while stall=1.
REQ-022 redirect has priority over stall and response: fetch_pc<=redirect_pc with bits[1:0] forced to 0, inst_valid<=0, inst<=NOP_INST.
REQ-023 redirect in WAIT without imem_rvalid, or in REQ with grant same cycle: set drop; next arriving response discarded, drop cleared, state -> REQ.
REQ-024 redirect in WAIT with imem_rvalid same cycle: response discarded, no drop set, state -> REQ.
REQ-025 redirect in REQ without grant: request address changes next cycle; instruction memory permits this before grant.
REQ-026 imem_rvalid outside WAIT ignored.
REQ-027 pc_add4 and fetch_pc increment modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-028 Latency: with imem_gnt immediate and 1-cycle read data, one instruction delivered every 2 cycles; inst_valid rises 3 cycles after reset release.

Reset
REQ-029 On rst: state=IDLE, fetch_pc=RESET_PC, pc_cur=RESET_PC, inst=NOP_INST, inst_valid=0, drop=0, imem_req=0, imem_addr=RESET_PC.
REQ-030 Reset asserted mid-WAIT abandons outstanding request; instruction memory shares rst so no stale response returns.

Structure
REQ-031 RESET_PC, NOP_INST and FSM state encodings reside in the shared CPU constants package, alongside opcode and write-back select constants.
REQ-032 One sub-module, pc_reg: 32-bit register with async reset to RESET_PC, load enable, and next-value input.

Verification
REQ-033 Reset release, gnt=1, 1-cycle rdata -> imem_addr 0x3000, 0x3004, 0x3008 in order; pc_add4=0x3004 while pc_cur=0x3000.
REQ-034 stall=1 for 4 cycles with inst_valid=1 -> inst, pc_cur constant, imem_req=0; fetch resumes cycle after stall drops.
REQ-035 redirect_pc=0x3103 during WAIT, rdata arriving 2 cycles later -> that word discarded, next imem_addr=0x3100, inst=NOP until refill.
REQ-036 redirect and imem_rvalid same cycle -> response dropped, drop stays 0, next request to redirect target.
REQ-037 fetch_pc=0xFFFF_FFFC -> pc_add4=0, next imem_addr=0.
REQ-038 rst asserted during WAIT with gnt=0 held afterwards -> outputs at reset values, imem_req=1 at 0x3000 after release.
